// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM/IO port between ICache fetches and
// LSB loads/stores. Each request is serialised into byte accesses; words are
// assembled and split little-endian, and completion is a one-cycle done pulse.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [ADDR_W-1:0] IoBase = ADDR_W'(IO_BASE);

    typedef enum logic [1:0] {StIdle, StIfRd, StLsRd, StLsWr} state_e;

    state_e            state_q;
    logic [2:0]        cnt_q;      // read: edges since grant; write: index of byte on the bus
    logic [2:0]        len_q;      // bytes minus one
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q;      // read bytes captured so far, upper bytes kept zero
    logic              last_ls_q;  // last grant went to the LSB
    logic              mem_wr_q;

    logic              if_ok, ls_ok, grant_if, grant_ls;
    logic [ADDR_W-1:0] addr_cur, addr_next;
    logic              stall_grant, stall_cur, stall_next;
    logic [7:0]        wr_byte_next;
    logic [31:0]       rd_word;

    // A stalled global ready must never let a write strobe reach the RAM.
    assign mem_wr = mem_wr_q && rdy;

    // Grant decision, byte addressing and IO back-pressure for the current cycle.
    always_comb begin
        if_ok        = if_req && !if_done && !clear;
        ls_ok        = ls_req && !ls_done;
        grant_if     = if_ok && (!ls_ok || last_ls_q);
        grant_ls     = ls_ok && (!if_ok || !last_ls_q);
        addr_cur     = addr_q + ADDR_W'(cnt_q);
        addr_next    = addr_q + ADDR_W'(cnt_q + 3'd1);
        stall_grant  = io_buffer_full && (ls_addr >= IoBase);
        stall_cur    = io_buffer_full && (addr_cur >= IoBase);
        stall_next   = io_buffer_full && (addr_next >= IoBase);
        wr_byte_next = 8'(wdata_q >> (8 * (cnt_q + 3'd1)));
        // Final read byte merged into the word so done and data leave together.
        rd_word      = buf_q | (32'(mem_din) << (8 * len_q));
    end

    // Arbitration FSM with all outputs registered; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            last_ls_q <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr_q  <= 1'b0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_data   <= '0;
            ls_rdata  <= '0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    buf_q <= '0;
                    if (grant_if) begin
                        state_q   <= StIfRd;
                        addr_q    <= if_addr;
                        len_q     <= 3'd3;
                        mem_a     <= if_addr;
                        last_ls_q <= 1'b0;
                    end else if (grant_ls) begin
                        addr_q    <= ls_addr;
                        len_q     <= {1'b0, ls_len};
                        wdata_q   <= ls_wdata;
                        mem_a     <= ls_addr;
                        last_ls_q <= 1'b1;
                        if (ls_wr) begin
                            state_q  <= StLsWr;
                            mem_dout <= ls_wdata[7:0];
                            mem_wr_q <= !stall_grant;
                        end else begin
                            state_q <= StLsRd;
                        end
                    end
                end
                StIfRd, StLsRd: begin
                    if (clear) begin
                        state_q <= StIdle;
                        mem_a   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        mem_a <= (cnt_q < len_q) ? addr_next : '0;
                        if (cnt_q != 3'd0) begin
                            buf_q <= buf_q | (32'(mem_din) << (8 * (cnt_q - 3'd1)));
                        end
                        if (cnt_q == len_q + 3'd1) begin
                            state_q <= StIdle;
                            if (state_q == StIfRd) begin
                                if_done <= 1'b1;
                                if_data <= rd_word;
                            end else begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rd_word;
                            end
                        end
                    end
                end
                StLsWr: begin
                    // Stores ignore clear: once granted they always complete.
                    if (mem_wr_q) begin
                        if (cnt_q == len_q) begin
                            state_q  <= StIdle;
                            mem_wr_q <= 1'b0;
                            mem_a    <= '0;
                            ls_done  <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_q + 3'd1;
                            mem_a    <= addr_next;
                            mem_dout <= wr_byte_next;
                            mem_wr_q <= !stall_next;
                        end
                    end else begin
                        mem_wr_q <= !stall_cur;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed timing checks followed by randomized traffic, with a
// byte-level memory reference model and scoreboard queues checked by a monitor.
module tb_mem_arbiter;

    localparam logic [31:0] IoBase = 32'h30000;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done;
    logic [1:0]  ls_len;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .IO_BASE(IoBase)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    typedef struct packed {
        logic        is_store;
        logic [31:0] data;
    } ls_exp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          if_seen = 0;
    int          ls_seen = 0;
    logic [7:0]  phys [logic [31:0]];   // what the DUT actually wrote
    logic [7:0]  refm [logic [31:0]];   // what the requesters intended to store
    logic [31:0] if_q[$];
    ls_exp_t     ls_q[$];
    logic [39:0] wr_q[$];               // {address, byte} in expected order
    int          order_q[$];            // 0 = IF done, 1 = LS done
    ls_exp_t     mon_e;
    logic [39:0] mon_w;
    int          k, n, pa, pb;
    bit          rnd_if_fin, rnd_ls_fin;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5a;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : init_byte(a);
    endfunction

    // Little-endian word of n bytes from the reference memory, upper bytes zero.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb);
        logic [31:0] w = '0;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic if_issue(input logic [31:0] a);
        if_q.push_back(ref_load(a, 4));
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic ls_issue(input logic wr, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] wd);
        ls_exp_t e;
        int nb = int'(len) + 1;
        e.is_store = wr;
        e.data     = wr ? 32'd0 : ref_load(a, nb);
        if (wr) begin
            for (int i = 0; i < nb; i++) begin
                refm[a + 32'(i)] = wd[8*i +: 8];
                wr_q.push_back({a + 32'(i), wd[8*i +: 8]});
            end
        end
        ls_q.push_back(e);
        ls_wr    = wr;
        ls_len   = len;
        ls_addr  = a;
        ls_wdata = wd;
        ls_req   = 1'b1;
    endtask

    task automatic wait_count(input bit is_ls, input int prev);
        int c = 0;
        while (((is_ls ? ls_seen : if_seen) == prev) && c < 400) begin
            step();
            c++;
        end
        if ((is_ls ? ls_seen : if_seen) == prev)
            check(is_ls ? "ls_done timeout" : "if_done timeout", 32'd0, 32'd1);
    endtask

    // RAM: one-cycle read latency; its output register also stalls on the global rdy.
    always @(posedge clk) begin
        if (rdy) mem_din <= phys.exists(mem_a) ? phys[mem_a] : init_byte(mem_a);
        if (mem_wr === 1'b1) phys[mem_a] = mem_dout;
    end

    // Monitor: a done is consumed on the edge where rdy is high.
    always @(negedge clk) begin
        if (rdy && if_done === 1'b1) begin
            if_seen++;
            order_q.push_back(0);
            if (if_q.size() == 0) check("unexpected if_done", 32'd1, 32'd0);
            else check("if_data", if_data, if_q.pop_front());
        end
        if (rdy && ls_done === 1'b1) begin
            ls_seen++;
            order_q.push_back(1);
            if (ls_q.size() == 0) check("unexpected ls_done", 32'd1, 32'd0);
            else begin
                mon_e = ls_q.pop_front();
                if (!mon_e.is_store) check("ls_rdata", ls_rdata, mon_e.data);
            end
        end
        if (mem_wr === 1'b1) begin
            if (wr_q.size() == 0) check("unexpected write", mem_a, 32'hffff_ffff);
            else begin
                mon_w = wr_q.pop_front();
                check("write addr", mem_a, mon_w[39:8]);
                check("write data", {24'd0, mem_dout}, {24'd0, mon_w[7:0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0; mem_din = '0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_len = '0; ls_addr = '0; ls_wdata = '0;
        rnd_if_fin = 1'b0; rnd_ls_fin = 1'b0;
        phys[32'h1000] = 8'h13; phys[32'h1001] = 8'h05;
        phys[32'h1002] = 8'h00; phys[32'h1003] = 8'h00;
        refm[32'h1000] = 8'h13; refm[32'h1001] = 8'h05;
        refm[32'h1002] = 8'h00; refm[32'h1003] = 8'h00;
        repeat (3) step();
        check("reset mem_a", mem_a, 32'd0);
        check("reset strobes", {29'd0, if_done, ls_done, mem_wr}, 32'd0);
        check("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        check("reset if_data", if_data, 32'd0);
        check("reset ls_rdata", ls_rdata, 32'd0);

        // Fetch right after reset release; cycle k is the k-th cycle after the grant edge.
        rst = 1'b1;
        if_issue(32'h1000);
        n = 0; pa = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c <= 4) check("t1 mem_a", mem_a, 32'h1000 + 32'(c - 1));
            if (if_done) begin
                n++;
                if (pa == 0) pa = c;
                if_req = 1'b0;
            end
        end
        check("t1 if_done cycle", 32'(pa), 32'd6);
        check("t1 if_done pulses", 32'(n), 32'd1);

        // Both requesting out of reset: LSB wins, IF follows on the done edge.
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        ls_issue(1'b0, 2'd3, 32'h2100, 32'd0);
        if_issue(32'h1040);
        step();
        check("t2 first grant LSB", mem_a, 32'h2100);
        k = 1;
        while (!ls_done && k < 20) begin
            step();
            k++;
        end
        check("t2 ls_done cycle", 32'(k), 32'd6);
        ls_req = 1'b0;
        step();
        check("t2 IF granted after ls_done", mem_a, 32'h1040);
        k = 0;
        while (!if_done && k < 20) begin
            step();
            k++;
        end
        check("t2 if_done cycle", 32'(k), 32'd5);
        if_req = 1'b0;
        step();

        // Both held continuously: grants alternate, starting with the LSB.
        order_q.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    pa = ls_seen;
                    ls_issue(1'b0, 2'd1, 32'h2200 + 32'(4 * i), 32'd0);
                    wait_count(1'b1, pa);
                end
                ls_req = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    pb = if_seen;
                    if_issue(32'h1100 + 32'(8 * i));
                    wait_count(1'b0, pb);
                end
                if_req = 1'b0;
            end
        join
        check("t2 done count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < order_q.size(); i++)
            check("t2 alternation", 32'(order_q[i]), 32'((i % 2 == 0) ? 1 : 0));
        step();

        // Two-byte store.
        ls_issue(1'b1, 2'd1, 32'h2000, 32'hAABBCCDD);
        for (int c = 1; c <= 4; c++) begin
            step();
            check("t3 mem_wr", {31'd0, mem_wr}, 32'(c <= 2));
            check("t3 ls_done", {31'd0, ls_done}, 32'(c == 3));
            if (ls_done) ls_req = 1'b0;
        end

        // IO store held off by a full buffer for three cycles.
        io_buffer_full = 1'b1;
        ls_issue(1'b1, 2'd0, 32'h30000, 32'h41);
        for (int c = 1; c <= 6; c++) begin
            step();
            check("t4 mem_wr", {31'd0, mem_wr}, 32'(c == 4));
            check("t4 ls_done", {31'd0, ls_done}, 32'(c == 5));
            if (ls_done) ls_req = 1'b0;
            if (c == 3) io_buffer_full = 1'b0;
        end

        // Flush during a fetch: abandoned, no done.
        if_addr = 32'h1200;
        if_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (if_done) n++;
            if (c == 3) begin
                check("t5 mem_a before clear", mem_a, 32'h1202);
                clear = 1'b1;
                if_req = 1'b0;
            end
            if (c == 4) begin
                check("t5 mem_a after clear", mem_a, 32'd0);
                clear = 1'b0;
            end
        end
        check("t5 no if_done", 32'(n), 32'd0);

        // Flush during a store: the store still completes.
        ls_issue(1'b1, 2'd3, 32'h2010, 32'h11223344);
        for (int c = 1; c <= 7; c++) begin
            step();
            check("t5 store mem_wr", {31'd0, mem_wr}, 32'(c <= 4));
            check("t5 store ls_done", {31'd0, ls_done}, 32'(c == 5));
            if (ls_done) ls_req = 1'b0;
            if (c == 2) clear = 1'b1;
            if (c == 3) clear = 1'b0;
        end

        // rdy low for two cycles mid-fetch: outputs hold and done slips by two.
        if_issue(32'h1000);
        for (int c = 1; c <= 9; c++) begin
            step();
            case (c)
                1: check("t6 mem_a", mem_a, 32'h1000);
                2: check("t6 mem_a", mem_a, 32'h1001);
                3, 4, 5: check("t6 mem_a held", mem_a, 32'h1002);
                6: check("t6 mem_a", mem_a, 32'h1003);
                default: ;
            endcase
            if (c == 4) check("t6 mem_wr held low", {31'd0, mem_wr}, 32'd0);
            check("t6 if_done", {31'd0, if_done}, 32'(c == 8));
            if (if_done) if_req = 1'b0;
            if (c == 3) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
        end

        // Reset mid-fetch: everything clears and the fetch never completes.
        if_addr = 32'h1300;
        if_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (if_done) n++;
            if (c == 3) begin
                rst = 1'b0;
                if_req = 1'b0;
            end
            if (c == 4) begin
                rst = 1'b1;
                check("t6 reset mem_a", mem_a, 32'd0);
                check("t6 reset if_data", if_data, 32'd0);
                check("t6 reset ls_rdata", ls_rdata, 32'd0);
                check("t6 reset strobes", {29'd0, if_done, ls_done, mem_wr}, 32'd0);
                check("t6 reset mem_dout", {24'd0, mem_dout}, 32'd0);
            end
        end
        check("t6 no done after reset", 32'(n), 32'd0);

        // Randomized traffic with random rdy and IO back-pressure.
        fork
            begin
                while (!(rnd_if_fin && rnd_ls_fin)) begin
                    step();
                    rdy = ($urandom_range(0, 4) != 0);
                    io_buffer_full = ($urandom_range(0, 2) == 0);
                end
                rdy = 1'b1;
                io_buffer_full = 1'b0;
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    pb = if_seen;
                    if_issue(32'h1000 + $urandom_range(0, 32'hEFF));
                    wait_count(1'b0, pb);
                    if_req = 1'b0;
                    repeat ($urandom_range(0, 2)) step();
                end
                rnd_if_fin = 1'b1;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic        wr;
                    logic [1:0]  len;
                    logic [31:0] a;
                    wr = 1'($urandom_range(0, 1));
                    case ($urandom_range(0, 2))
                        0: len = 2'd0;
                        1: len = 2'd1;
                        default: len = 2'd3;
                    endcase
                    if (wr && $urandom_range(0, 3) == 0) a = IoBase + $urandom_range(0, 255);
                    else a = 32'h2000 + $urandom_range(0, 63);
                    pa = ls_seen;
                    ls_issue(wr, len, a, $urandom);
                    wait_count(1'b1, pa);
                    ls_req = 1'b0;
                    repeat ($urandom_range(0, 2)) step();
                end
                rnd_ls_fin = 1'b1;
            end
        join
        repeat (10) step();
        check("if queue drained", 32'(if_q.size()), 32'd0);
        check("ls queue drained", 32'(ls_q.size()), 32'd0);
        check("write queue drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
